// File: rtl/imu_packet_rx.sv
// rtl/imu_packet_rx.sv - UART receiver and 18-byte IMU packet parser with commit/error reporting
module imu_packet_rx #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               uart_rx_i,
  output logic signed [15:0] accel_x_o,
  output logic signed [15:0] accel_y_o,
  output logic signed [15:0] accel_z_o,
  output logic signed [15:0] gyro_x_o,
  output logic signed [15:0] gyro_y_o,
  output logic signed [15:0] gyro_z_o,
  output logic signed [15:0] temp_o,
  output logic               data_valid_o,
  output logic               err_o,
  output logic        [15:0] pkt_count_o,
  output logic        [7:0]  err_count_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {HUNT_AA, HUNT_55, PAYLOAD, TAIL_CR, TAIL_LF} p_state_e;

  logic             sync1_q, sync2_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb, frame_err;

  p_state_e         p_state_q, p_state_d;
  logic [3:0]       idx_q, idx_d;
  logic [13:0][7:0] shadow_q, shadow_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [6:0][15:0] vals_q, vals_d;
  logic             data_valid_q, data_valid_d;
  logic             err_q, err_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             err_det;

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (bit_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          bit_cnt_d  = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          byte_stb   = sync2_q;
          frame_err  = !sync2_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A framing error outranks everything; a byte strobe suppresses a coincident timeout.
  always_comb begin
    p_state_d    = p_state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    vals_d       = vals_q;
    data_valid_d = 1'b0;
    pkt_count_d  = pkt_count_q;
    err_det      = 1'b0;
    if (frame_err) begin
      err_det   = 1'b1;
      p_state_d = HUNT_AA;
    end else if (byte_stb) begin
      case (p_state_q)
        HUNT_AA: if (shift_q == 8'hAA) p_state_d = HUNT_55;
        HUNT_55: begin
          if (shift_q == 8'h55) begin
            p_state_d = PAYLOAD;
            idx_d     = 4'd0;
          end else if (shift_q != 8'hAA) begin
            p_state_d = HUNT_AA;
          end
        end
        PAYLOAD: begin
          shadow_d[idx_q] = shift_q;
          if (idx_q == 4'd13) p_state_d = TAIL_CR;
          else                idx_d     = idx_q + 4'd1;
        end
        TAIL_CR: begin
          if (shift_q == 8'h0D) begin
            p_state_d = TAIL_LF;
          end else begin
            err_det   = 1'b1;
            p_state_d = HUNT_AA;
          end
        end
        TAIL_LF: begin
          p_state_d = HUNT_AA;
          if (shift_q == 8'h0A) begin
            for (int i = 0; i < 7; i++) vals_d[i] = {shadow_q[2*i], shadow_q[2*i+1]};
            data_valid_d = 1'b1;
            pkt_count_d  = pkt_count_q + 16'd1;
          end else begin
            err_det = 1'b1;
          end
        end
        default: p_state_d = HUNT_AA;
      endcase
    end else if (p_state_q != HUNT_AA && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      err_det   = 1'b1;
      p_state_d = HUNT_AA;
    end
    to_cnt_d    = (p_state_q == HUNT_AA || byte_stb || err_det) ? '0 : to_cnt_q + TO_W'(1);
    err_d       = err_det;
    err_count_d = (err_det && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      p_state_q    <= HUNT_AA;
      idx_q        <= 4'd0;
      shadow_q     <= '0;
      to_cnt_q     <= '0;
      vals_q       <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      pkt_count_q  <= 16'd0;
      err_count_q  <= 8'd0;
    end else begin
      sync1_q      <= uart_rx_i;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      p_state_q    <= p_state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      to_cnt_q     <= to_cnt_d;
      vals_q       <= vals_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign accel_x_o    = vals_q[0];
  assign accel_y_o    = vals_q[1];
  assign accel_z_o    = vals_q[2];
  assign gyro_x_o     = vals_q[3];
  assign gyro_y_o     = vals_q[4];
  assign gyro_z_o     = vals_q[5];
  assign temp_o       = vals_q[6];
  assign data_valid_o = data_valid_q;
  assign err_o        = err_q;
  assign pkt_count_o  = pkt_count_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_imu_packet_rx.sv
// tb/tb_imu_packet_rx.sv - packet-level vector table plus randomized packets for imu_packet_rx
module tb_imu_packet_rx;
  localparam int CLK_HZ = 400_000;
  localparam int BAUD   = 100_000;
  localparam int TO_BITS = 40;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic signed [15:0] ax, ay, az, gx, gy, gz, tp;
  logic dv, err;
  logic [15:0] pkt_cnt;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  imu_packet_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
    .accel_x_o(ax), .accel_y_o(ay), .accel_z_o(az),
    .gyro_x_o(gx), .gyro_y_o(gy), .gyro_z_o(gz), .temp_o(tp),
    .data_valid_o(dv), .err_o(err), .pkt_count_o(pkt_cnt), .err_count_o(err_cnt)
  );

  typedef struct {
    logic [6:0][15:0] vals;
    bit               garbage;
    int               bad_stop;
    int               trunc;
    logic [7:0]       cr;
    logic [7:0]       lf;
    int               exp_good;
    int               exp_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int dv_seen = 0;
  int err_seen = 0;
  logic [6:0][15:0] m_vals = '0;
  int m_pkt = 0;
  int m_errc = 0;
  logic [7:0] stream_q[$];
  vec_t tbl[$];

  always @(negedge clk) begin
    if (dv) dv_seen++;
    if (err) err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_val(input int i);
    case (i)
      0: dut_val = ax;
      1: dut_val = ay;
      2: dut_val = az;
      3: dut_val = gx;
      4: dut_val = gy;
      5: dut_val = gz;
      default: dut_val = tp;
    endcase
  endfunction

  function automatic vec_t mk(input logic [111:0] flat, input bit garbage, input int bad_stop,
                              input int trunc, input logic [7:0] cr, input logic [7:0] lf,
                              input int g, input int e);
    vec_t v;
    for (int i = 0; i < 7; i++) v.vals[i] = flat[111-16*i -: 16];
    v.garbage = garbage; v.bad_stop = bad_stop; v.trunc = trunc;
    v.cr = cr; v.lf = lf; v.exp_good = g; v.exp_err = e;
    return v;
  endfunction

  // Outcome from packet rules: any single fault kills the packet with exactly one error.
  function automatic void model_expect(inout vec_t v);
    if (v.bad_stop >= 0 || v.trunc >= 1 || v.cr != 8'h0D || v.lf != 8'h0A) begin
      v.exp_good = 0; v.exp_err = 1;
    end else begin
      v.exp_good = 1; v.exp_err = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_vec(input vec_t v, input bit do_idle);
    int n;
    stream_q.delete();
    if (v.garbage) begin
      stream_q.push_back(8'h00); stream_q.push_back(8'hAA);
    end
    stream_q.push_back(8'hAA); stream_q.push_back(8'h55);
    for (int i = 0; i < 7; i++) begin
      stream_q.push_back(v.vals[i][15:8]); stream_q.push_back(v.vals[i][7:0]);
    end
    stream_q.push_back(v.cr); stream_q.push_back(v.lf);
    n = (v.trunc >= 1) ? v.trunc : stream_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == v.bad_stop) begin
        send_byte(stream_q[i], 1'b0);
        break;
      end
      send_byte(stream_q[i], 1'b1);
    end
    if (do_idle) idle_bits(TO_BITS + 5);
  endtask

  task automatic model_apply(input vec_t v);
    if (v.exp_good > 0) m_vals = v.vals;
    m_pkt += v.exp_good;
    m_errc = (m_errc + v.exp_err > 255) ? 255 : m_errc + v.exp_err;
  endtask

  task automatic check_state(input string name, input int dv0, input int e0, input int g, input int e);
    check({name, " dv_pulses"}, dv_seen - dv0, g);
    check({name, " err_pulses"}, err_seen - e0, e);
    check({name, " pkt_count"}, pkt_cnt, m_pkt[15:0]);
    check({name, " err_count"}, err_cnt, m_errc);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s value%0d", name, i), dut_val(i), m_vals[i]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int dv0, e0;
    dv0 = dv_seen; e0 = err_seen;
    send_vec(v, 1'b1);
    model_apply(v);
    check_state(name, dv0, e0, v.exp_good, v.exp_err);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int kind;
    for (int i = 0; i < 7; i++) v.vals[i] = 16'($urandom);
    v.garbage = 1'b0; v.bad_stop = -1; v.trunc = -1; v.cr = 8'h0D; v.lf = 8'h0A;
    kind = $urandom_range(0, 4);
    case (kind)
      1: v.bad_stop = $urandom_range(0, 17);
      2: v.trunc = $urandom_range(1, 16);
      3: if ($urandom_range(0, 1) == 1) v.cr = 8'h0D ^ 8'($urandom_range(1, 255));
         else                           v.lf = 8'h0A ^ 8'($urandom_range(1, 255));
      default: ;
    endcase
    model_expect(v);
    return v;
  endfunction

  initial begin
    int dv0, e0;
    vec_t v, w;
    tbl.push_back(mk({16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h00FF, 16'hFF00}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0));
    tbl.push_back(mk({16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E}, 1, -1, -1, 8'h0D, 8'h0A, 1, 0));
    tbl.push_back(mk({16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777}, 0, -1, -1, 8'h0D, 8'h0B, 0, 1));
    tbl.push_back(mk({16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888}, 0, 5, -1, 8'h0D, 8'h0A, 0, 1));
    tbl.push_back(mk({16'hA5A5, 16'h5A5A, 16'h0000, 16'hFFFE, 16'h8001, 16'h7F00, 16'h00AA}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0));
    tbl.push_back(mk({16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999}, 0, -1, 5, 8'h0D, 8'h0A, 0, 1));
    tbl.push_back(mk({16'hCAFE, 16'hBEEF, 16'h0D0A, 16'h55AA, 16'h1357, 16'h2468, 16'hFACE}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0));
    tbl.push_back(mk({16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA}, 0, -1, -1, 8'h0C, 8'h0A, 0, 1));
    tbl.push_back(mk({16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB}, 0, 0, -1, 8'h0D, 8'h0A, 0, 1));
    tbl.push_back(mk({16'h0F0F, 16'hF0F0, 16'h1234, 16'h4321, 16'h8765, 16'h5678, 16'h9ABC}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0));

    rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset", dv_seen, err_seen, 0, 0);
    check("reset dv_level", dv, 0);
    check("reset err_level", err, 0);
    rst_n = 1'b1;
    idle_bits(3);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++) run_vec(rand_vec(), $sformatf("rand%0d", i));

    v = mk({16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213, 16'h1415, 16'h1617}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0);
    w = mk({16'h8181, 16'h7E7E, 16'hAA55, 16'h55AA, 16'h0D0A, 16'hFFFF, 16'h0001}, 0, -1, -1, 8'h0D, 8'h0A, 1, 0);
    dv0 = dv_seen; e0 = err_seen;
    send_vec(v, 1'b0);
    send_vec(w, 1'b1);
    model_apply(v); model_apply(w);
    check_state("back_to_back", dv0, e0, 2, 0);

    dv0 = dv_seen; e0 = err_seen;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h00, 1'b0);
      idle_bits(2);
    end
    m_errc = 255;
    check("saturate err_pulses", err_seen - e0, 260);
    check("saturate err_count", err_cnt, 8'hFF);
    check("saturate dv_pulses", dv_seen - dv0, 0);

    dv0 = dv_seen; e0 = err_seen;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h3C, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    m_vals = '0; m_pkt = 0; m_errc = 0;
    repeat (3) @(negedge clk);
    check_state("in_reset", dv0, e0, 0, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(TO_BITS + 5);
    check("post_reset err_pulses", err_seen - e0, 0);
    run_vec(tbl[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
